// File: rtl/bio_cg_pkg.sv
// Shared types and default parameters for the clock-gate sequencer.
package bio_cg_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'b00,
        WAKE = 2'b01,
        ON   = 2'b10,
        HOLD = 2'b11
    } cg_state_t;

    localparam int NCH_DEF      = 4;
    localparam int HOLD_W_DEF   = 8;
    localparam int WAKE_CYC_DEF = 2;

endpackage

// File: rtl/bio_cg_rr_arb.sv
// Round-robin one-hot grant; the search starts at the pointer, and the pointer
// moves past the winner whenever a grant is issued.
module bio_cg_rr_arb #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  cand_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic          found;
    int            win;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win     = 0;
        for (int k = 0; k < N; k++) begin
            if (!found && cand_i[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = (int'(ptr_q) + k) % N;
            end
        end
        if (en_i && found) grant_o[win] = 1'b1;
        ptr_d = (en_i && found) ? PW'((win + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/bio_clkgate_ctrl.sv
// Sequences NCH ICG enables from run requests: staggered wake with settle delay,
// idle hold-off before gating, registered enable/ack/busy outputs.
module bio_clkgate_ctrl
    import bio_cg_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int HOLD_W   = HOLD_W_DEF,
    parameter int WAKE_CYC = WAKE_CYC_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    force_on,
    input  logic [HOLD_W-1:0] hold_cyc,
    input  logic              test_en,
    output logic [NCH-1:0]    icg_en,
    output logic              icg_se,
    output logic [NCH-1:0]    clk_ack,
    output logic              wake_busy
);

    localparam int WCW = $clog2(WAKE_CYC + 1);
    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] run, cand, grant, in_wake, nxt_wake;
    logic [PW-1:0]  rr_ptr;
    logic           wake_busy_q;

    assign run = req | force_on;

    // Grants only while nothing is waking, so a channel leaving WAKE on one edge
    // leaves one idle cycle before the next wake starts.
    bio_cg_rr_arb #(.N(NCH), .PW(PW)) u_arb (
        .clk     (clk),
        .rst_n   (resetn),
        .cand_i  (cand),
        .en_i    (~|in_wake),
        .grant_o (grant),
        .ptr_o   (rr_ptr)
    );

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        cg_state_t         st_q, st_d;
        logic [WCW-1:0]    wcnt_q, wcnt_d;
        logic [HOLD_W-1:0] hcnt_q, hcnt_d;
        logic              en_q, ack_q;

        always_comb begin
            st_d   = st_q;
            wcnt_d = wcnt_q;
            hcnt_d = hcnt_q;
            case (st_q)
                OFF: if (grant[i]) begin
                    st_d   = WAKE;
                    wcnt_d = WCW'(WAKE_CYC - 1);
                end
                WAKE: if (wcnt_q == '0) st_d = ON;
                      else              wcnt_d = wcnt_q - WCW'(1);
                ON: if (!run[i]) begin
                    if (hold_cyc != '0) begin
                        st_d   = HOLD;
                        hcnt_d = hold_cyc;
                    end else begin
                        st_d = OFF;
                    end
                end
                HOLD: if (run[i])                   st_d = ON;
                      else if (hcnt_q == HOLD_W'(1)) st_d = OFF;
                      else                           hcnt_d = hcnt_q - HOLD_W'(1);
                default: st_d = OFF;
            endcase
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                st_q   <= OFF;
                wcnt_q <= '0;
                hcnt_q <= '0;
                en_q   <= 1'b0;
                ack_q  <= 1'b0;
            end else begin
                st_q   <= st_d;
                wcnt_q <= wcnt_d;
                hcnt_q <= hcnt_d;
                en_q   <= (st_d != OFF);
                ack_q  <= (st_d == ON) || (st_d == HOLD);
            end
        end

        assign cand[i]     = run[i] && (st_q == OFF);
        assign in_wake[i]  = (st_q == WAKE);
        assign nxt_wake[i] = (st_d == WAKE);
        assign icg_en[i]   = en_q;
        assign clk_ack[i]  = ack_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wake_busy_q <= 1'b0;
        else         wake_busy_q <= |nxt_wake;
    end

    assign wake_busy = wake_busy_q;
    assign icg_se    = test_en;

    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;

endmodule

// File: tb/tb_bio_clkgate_ctrl.sv
// Directed bench for bio_clkgate_ctrl (NCH=4, HOLD_W=8, WAKE_CYC=2).
module tb_bio_clkgate_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic [3:0] req, force_on;
    logic [7:0] hold_cyc;
    logic       test_en;
    logic [3:0] icg_en, clk_ack;
    logic       icg_se, wake_busy;

    int n_tests = 0;
    int n_fail  = 0;

    bio_clkgate_ctrl #(.NCH(4), .HOLD_W(8), .WAKE_CYC(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .force_on  (force_on),
        .hold_cyc  (hold_cyc),
        .test_en   (test_en),
        .icg_en    (icg_en),
        .icg_se    (icg_se),
        .clk_ack   (clk_ack),
        .wake_busy (wake_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        req      = '0;
        force_on = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req = '0; force_on = '0; hold_cyc = 8'd5; test_en = 1'b0;
        tick();
        n_tests++;
        if ({icg_en, clk_ack, wake_busy} !== 9'b0) begin
            $display("FAIL reset: en=%b ack=%b busy=%b, want all 0", icg_en, clk_ack, wake_busy);
            n_fail++;
        end
        tick();
        resetn = 1'b1;
    endtask

    // Single wake: enable right after the grant edge, ack two edges later.
    task automatic test_wake_latency();
        logic [8:0] exp_v [1:3];
        exp_v[1] = {4'b0001, 4'b0000, 1'b1};
        exp_v[2] = {4'b0001, 4'b0000, 1'b1};
        exp_v[3] = {4'b0001, 4'b0001, 1'b0};
        req = 4'b0001;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_tests++;
            if ({icg_en, clk_ack, wake_busy} !== exp_v[t]) begin
                $display("FAIL wake_latency t%0d: en/ack/busy=%b want %b", t, {icg_en, clk_ack, wake_busy}, exp_v[t]);
                n_fail++;
            end
        end
    endtask

    // ch0 is ON on entry; hold_cyc=5.
    task automatic test_hold();
        req = 4'b0000;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_tests++;
            if (icg_en !== 4'b0001 || clk_ack !== 4'b0001) begin
                $display("FAIL hold_keep c%0d: en=%b ack=%b want 0001/0001", t, icg_en, clk_ack);
                n_fail++;
            end
        end
        tick();
        n_tests++;
        if (icg_en !== 4'b0000 || clk_ack !== 4'b0000) begin
            $display("FAIL hold_expire: en=%b ack=%b want 0000/0000", icg_en, clk_ack);
            n_fail++;
        end
        req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b0000;
        tick(); tick();
        req = 4'b0001;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++;
            if (icg_en !== 4'b0001 || clk_ack !== 4'b0001 || wake_busy !== 1'b0) begin
                $display("FAIL hold_rearm c%0d: en=%b ack=%b busy=%b want 0001/0001/0", t, icg_en, clk_ack, wake_busy);
                n_fail++;
            end
        end
    endtask

    // All four requests at once: grant at edges 1,4,7,10; ack 2 edges after each.
    task automatic test_stagger();
        logic [3:0] e_en, e_ack;
        logic       e_busy;
        do_reset();
        req = 4'b1111;
        for (int t = 1; t <= 13; t++) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                e_en[k]  = (t >= 1 + 3 * k);
                e_ack[k] = (t >= 3 + 3 * k);
            end
            e_busy = (t % 3 != 0) && (t <= 11);
            n_tests++;
            if (icg_en !== e_en || clk_ack !== e_ack || wake_busy !== e_busy) begin
                $display("FAIL stagger t%0d: en=%b ack=%b busy=%b want %b/%b/%b", t, icg_en, clk_ack, wake_busy, e_en, e_ack, e_busy);
                n_fail++;
            end
        end
    endtask

    // Pointer left at 2 by a lone ch1 grant; then ch1 and ch3 compete.
    task automatic test_rr_fair();
        do_reset();
        hold_cyc = 8'd0;
        req = 4'b0010;
        tick(); tick(); tick();
        req = 4'b0000;
        tick();
        n_tests++;
        if (icg_en !== 4'b0000) begin
            $display("FAIL rr_setup: en=%b want 0000", icg_en);
            n_fail++;
        end
        req = 4'b1010;
        tick();
        n_tests++;
        if (icg_en !== 4'b1000) begin
            $display("FAIL rr_first: en=%b want 1000", icg_en);
            n_fail++;
        end
        tick(); tick();
        n_tests++;
        if (icg_en !== 4'b1000 || clk_ack !== 4'b1000) begin
            $display("FAIL rr_gap: en=%b ack=%b want 1000/1000", icg_en, clk_ack);
            n_fail++;
        end
        tick();
        n_tests++;
        if (icg_en !== 4'b1010 || wake_busy !== 1'b1) begin
            $display("FAIL rr_second: en=%b busy=%b want 1010/1", icg_en, wake_busy);
            n_fail++;
        end
    endtask

    task automatic test_zero_hold_force();
        do_reset();
        hold_cyc = 8'd0;
        req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b0000;
        tick();
        n_tests++;
        if (icg_en !== 4'b0000 || clk_ack !== 4'b0000) begin
            $display("FAIL zero_hold: en=%b ack=%b want 0000/0000", icg_en, clk_ack);
            n_fail++;
        end
        force_on = 4'b0100;
        tick();
        n_tests++;
        if (icg_en !== 4'b0100 || clk_ack !== 4'b0000) begin
            $display("FAIL force_wake: en=%b ack=%b want 0100/0000", icg_en, clk_ack);
            n_fail++;
        end
        for (int t = 0; t < 4; t++) tick();
        n_tests++;
        if (icg_en !== 4'b0100 || clk_ack !== 4'b0100 || wake_busy !== 1'b0) begin
            $display("FAIL force_on: en=%b ack=%b busy=%b want 0100/0100/0", icg_en, clk_ack, wake_busy);
            n_fail++;
        end
        force_on = 4'b0000;
    endtask

    task automatic test_async_reset_test_en();
        do_reset();
        hold_cyc = 8'd5;
        req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b0010;
        tick();
        n_tests++;
        if (icg_en !== 4'b0011 || clk_ack !== 4'b0001 || wake_busy !== 1'b1) begin
            $display("FAIL pre_reset: en=%b ack=%b busy=%b want 0011/0001/1", icg_en, clk_ack, wake_busy);
            n_fail++;
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({icg_en, clk_ack, wake_busy} !== 9'b0) begin
            $display("FAIL async_reset: en=%b ack=%b busy=%b want all 0", icg_en, clk_ack, wake_busy);
            n_fail++;
        end
        do_reset();
        req = 4'b0001;
        tick(); tick(); tick();
        test_en = 1'b1;
        #1;
        n_tests++;
        if (icg_se !== 1'b1 || icg_en !== 4'b0001) begin
            $display("FAIL test_en_hi: se=%b en=%b want 1/0001", icg_se, icg_en);
            n_fail++;
        end
        tick();
        n_tests++;
        if (icg_en !== 4'b0001 || clk_ack !== 4'b0001) begin
            $display("FAIL test_en_fsm: en=%b ack=%b want 0001/0001", icg_en, clk_ack);
            n_fail++;
        end
        test_en = 1'b0;
        #1;
        n_tests++;
        if (icg_se !== 1'b0) begin
            $display("FAIL test_en_lo: se=%b want 0", icg_se);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_wake_latency();
        test_hold();
        test_stagger();
        test_rr_fair();
        test_zero_hold_force();
        test_async_reset_test_en();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
